// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port among NUM_PORTS toggle-handshake
// requesters and injects periodic auto-refresh commands ahead of any port traffic.
// Optional feature: define SDRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// without it the lowest pending port index always wins (fixed priority).
module sdram_arbiter #(
    parameter int ADDR_BITS        = 22,
    parameter int NUM_PORTS        = 3,
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                req,
    output logic [NUM_PORTS-1:0]                ack,
    input  logic [NUM_PORTS-1:0]                we,
    input  logic [NUM_PORTS-1:0][ADDR_BITS-1:0] addr,
    input  logic [NUM_PORTS-1:0][15:0]          wdata,
    output logic [15:0]                         rdata,
    output logic                                mem_req,
    input  logic                                mem_ack,
    output logic                                mem_refresh,
    output logic                                mem_we,
    output logic [ADDR_BITS-1:0]                mem_addr,
    output logic [15:0]                         mem_wdata,
    input  logic [15:0]                         mem_rdata,
    output logic                                refresh_overrun
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_INTERVAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_XFER,
        WAIT_REF
    } state_t;

    state_t               state;
    logic [CW-1:0]        ref_cnt;
    logic                 refresh_due;
    logic [PW-1:0]        g;
    logic [PW-1:0]        grant;
    logic [NUM_PORTS-1:0] pending;
    logic                 wrap;
    logic                 ctrl_done;
    logic                 ref_done;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    logic [PW-1:0]        ptr;
    logic [PW:0]          cand;
`endif

    assign pending   = req ^ ack;
    assign wrap      = (ref_cnt == CNT_LAST);
    assign ctrl_done = (mem_ack == mem_req);
    assign ref_done  = (state == WAIT_REF) && ctrl_done;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    // Round-robin pick: scan downward so the candidate closest to ptr is written last and wins.
    always_comb begin
        grant = '0;
        cand  = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PW + 1)'(k);
            if (cand >= (PW + 1)'(NUM_PORTS)) begin
                cand = cand - (PW + 1)'(NUM_PORTS);
            end
            if (pending[cand[PW-1:0]]) begin
                grant = cand[PW-1:0];
            end
        end
    end
`else
    // Fixed-priority pick: the lowest pending index is written last and wins.
    always_comb begin
        grant = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (pending[PW'(k)]) begin
                grant = PW'(k);
            end
        end
    end
`endif

    // Free-running refresh interval counter; its wrap marks a new refresh as owed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
        end else if (wrap) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // Main arbitration FSM together with the owed-refresh bookkeeping it consumes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ack             <= '0;
            rdata           <= '0;
            mem_req         <= 1'b0;
            mem_refresh     <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            refresh_due     <= 1'b0;
            refresh_overrun <= 1'b0;
            g               <= '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            ptr             <= '0;
`endif
        end else begin
            if (wrap) begin
                refresh_due <= 1'b1;
                if (refresh_due && !ref_done) begin
                    refresh_overrun <= 1'b1;
                end
            end else if (ref_done) begin
                refresh_due <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (refresh_due) begin
                        mem_refresh <= 1'b1;
                        mem_req     <= ~mem_req;
                        state       <= WAIT_REF;
                    end else if (|pending) begin
                        g           <= grant;
                        mem_we      <= we[grant];
                        mem_addr    <= addr[grant];
                        mem_wdata   <= wdata[grant];
                        mem_refresh <= 1'b0;
                        mem_req     <= ~mem_req;
                        state       <= WAIT_XFER;
                    end
                end
                WAIT_XFER: begin
                    if (ctrl_done) begin
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        ack[g] <= ~ack[g];
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                        if (g == PW'(NUM_PORTS - 1)) begin
                            ptr <= '0;
                        end else begin
                            ptr <= g + 1'b1;
                        end
`endif
                        state <= IDLE;
                    end
                end
                WAIT_REF: begin
                    if (ctrl_done) begin
                        mem_refresh <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
